ems_page_mapper: RTL and testbench

//  EMS page-register controller feeding the SDRAM RAM stage: holds four 16KB page mappings and a control register written over XT I/O.

---
 rtl/ems_page_mapper.sv | 190 +++++++++++++++++++
 tb/tb_ems_page_mapper.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ems_page_mapper.sv
`default_nettype none
// ============================================================================
//  Module      : ems_page_mapper
//  Description : EMS page-register controller. Four 16KB page mappings plus
//                a control register, written over XT I/O through a 2-entry
//                write queue that drains only between memory cycles. Decodes
//                the CPU address into one-hot frame-page selects and 7-bit
//                page numbers for the SDRAM stage.
//  Revision    : 1.0  initial release
// ============================================================================
module ems_page_mapper #(
    parameter logic [9:0] IO_BASE = 10'h260
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [19:0] address,
    input  logic [7:0]  internal_data_bus,
    input  logic        io_read_n,
    input  logic        io_write_n,
    input  logic        memory_read_n,
    input  logic        memory_write_n,
    output logic [7:0]  data_bus_out,
    output logic        io_select_n,
    output logic [6:0]  map_ems [0:3],
    output logic        ems_b1,
    output logic        ems_b2,
    output logic        ems_b3,
    output logic        ems_b4,
    output logic        ems_enable
);

    localparam logic [2:0] c_CTRL_INDEX = 3'd4;

    // Committed register state
    logic [7:0]  r_page [0:3];
    logic        r_enable;
    logic        r_overflow;
    logic [1:0]  r_frame_sel;

    // Write queue: {index[2:0], data[7:0]} per entry
    logic [10:0] r_fifo [0:1];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;

    // Strobe edge detection and control-read tracking
    logic        r_prev_wr_n;
    logic        r_prev_rd_n;
    logic        r_ctrl_rd_latched;

    // I/O window decode: wrap-around subtraction bounds the index to 0..4
    logic [9:0]  w_offset;
    logic        w_hit;
    logic [2:0]  w_index;
    assign w_offset = address[9:0] - IO_BASE;
    assign w_hit    = (w_offset < 10'd5);
    assign w_index  = w_offset[2:0];

    logic        w_strobe;
    logic        w_mem_idle;
    logic        w_pop;
    logic        w_full;
    logic        w_push;
    logic        w_drop;
    logic        w_rd_rise;
    logic [10:0] w_head;
    assign w_strobe   = r_prev_wr_n & ~io_write_n & w_hit;
    assign w_mem_idle = memory_read_n & memory_write_n;
    assign w_pop      = (r_count != 2'd0) & w_mem_idle;
    assign w_full     = (r_count == 2'd2);
    // A pop on the same edge frees the slot, so a full queue still accepts
    assign w_push     = w_strobe & (~w_full | w_pop);
    assign w_drop     = w_strobe & w_full & ~w_pop;
    assign w_rd_rise  = ~r_prev_rd_n & io_read_n;
    assign w_head     = r_fifo[r_rd_ptr];

    // Readback source selection from committed state only
    logic [7:0]  w_reg_val;
    always_comb begin
        w_reg_val = 8'h00;
        case (w_index)
            3'd0:        w_reg_val = r_page[0];
            3'd1:        w_reg_val = r_page[1];
            3'd2:        w_reg_val = r_page[2];
            3'd3:        w_reg_val = r_page[3];
            c_CTRL_INDEX: w_reg_val = {r_enable, r_overflow, 4'b0000, r_frame_sel};
            default:     w_reg_val = 8'h00;
        endcase
    end

    // Write queue storage, pointers and occupancy
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fifo[0] <= 11'd0;
            r_fifo[1] <= 11'd0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= {w_index, internal_data_bus};
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Commit queue head into the page/control registers; sticky overflow
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_page[0]   <= 8'h00;
            r_page[1]   <= 8'h00;
            r_page[2]   <= 8'h00;
            r_page[3]   <= 8'h00;
            r_enable    <= 1'b0;
            r_frame_sel <= 2'b00;
            r_overflow  <= 1'b0;
        end else begin
            if (w_pop) begin
                if (w_head[10:8] == c_CTRL_INDEX) begin
                    // Bit 6 is the overflow flag and is not software-writable
                    r_enable    <= w_head[7];
                    r_frame_sel <= w_head[1:0];
                end else if (w_head[10] == 1'b0) begin
                    r_page[w_head[9:8]] <= w_head[7:0];
                end
            end
            // A drop on the clearing edge wins
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (r_ctrl_rd_latched && w_rd_rise) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Strobe history, control-read latch and registered readback
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_wr_n       <= 1'b1;
            r_prev_rd_n       <= 1'b1;
            r_ctrl_rd_latched <= 1'b0;
            data_bus_out      <= 8'h00;
        end else begin
            r_prev_wr_n <= io_write_n;
            r_prev_rd_n <= io_read_n;
            if (w_hit && !io_read_n && (w_index == c_CTRL_INDEX)) begin
                r_ctrl_rd_latched <= 1'b1;
            end else if (w_rd_rise) begin
                r_ctrl_rd_latched <= 1'b0;
            end
            data_bus_out <= (w_hit && !io_read_n) ? w_reg_val : 8'h00;
        end
    end

    assign io_select_n = ~(w_hit & ~io_read_n);
    assign ems_enable  = r_enable;

    // Page numbers exported regardless of their valid bit
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_map
            assign map_ems[gi] = r_page[gi][6:0];
        end
    endgenerate

    // Frame decode: the selected 64KB segment split into four 16KB pages
    logic       w_seg;
    logic       w_frame_on;
    logic [1:0] w_n;
    assign w_seg      = (address[19:16] == {2'b11, r_frame_sel});
    assign w_frame_on = r_enable & (r_frame_sel != 2'b11) & w_seg;
    assign w_n        = address[15:14];
    assign ems_b1     = w_frame_on & (w_n == 2'd0) & r_page[0][7];
    assign ems_b2     = w_frame_on & (w_n == 2'd1) & r_page[1][7];
    assign ems_b3     = w_frame_on & (w_n == 2'd2) & r_page[2][7];
    assign ems_b4     = w_frame_on & (w_n == 2'd3) & r_page[3][7];

    // Address bits 13:10 play no part in either decode
    logic w_unused_addr;
    assign w_unused_addr = ^address[13:10];

endmodule
`default_nettype wire

// File: tb/tb_ems_page_mapper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ems_page_mapper
//  Description : Directed self-checking bench for ems_page_mapper.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ems_page_mapper;

    logic        clock;
    logic        reset_n;
    logic [19:0] address;
    logic [7:0]  internal_data_bus;
    logic        io_read_n;
    logic        io_write_n;
    logic        memory_read_n;
    logic        memory_write_n;
    logic [7:0]  data_bus_out;
    logic        io_select_n;
    logic [6:0]  map_ems [0:3];
    logic        ems_b1;
    logic        ems_b2;
    logic        ems_b3;
    logic        ems_b4;
    logic        ems_enable;

    int checks = 0;
    int errors = 0;

    ems_page_mapper #(.IO_BASE(10'h260)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .address           (address),
        .internal_data_bus (internal_data_bus),
        .io_read_n         (io_read_n),
        .io_write_n        (io_write_n),
        .memory_read_n     (memory_read_n),
        .memory_write_n    (memory_write_n),
        .data_bus_out      (data_bus_out),
        .io_select_n       (io_select_n),
        .map_ems           (map_ems),
        .ems_b1            (ems_b1),
        .ems_b2            (ems_b2),
        .ems_b3            (ems_b3),
        .ems_b4            (ems_b4),
        .ems_enable        (ems_enable)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // All four frame selects packed as {b4,b3,b2,b1}
    function automatic logic [7:0] ems_vec();
        return {4'b0000, ems_b4, ems_b3, ems_b2, ems_b1};
    endfunction

    // One I/O write pulse: push on the first edge, possible commit on the next
    task automatic io_write(input logic [9:0] port, input logic [7:0] d);
        address           = {10'h000, port};
        internal_data_bus = d;
        io_write_n        = 1'b0;
        @(negedge clock);
        io_write_n        = 1'b1;
        @(negedge clock);
    endtask

    // One I/O read pulse with readback check; read strobe rises afterwards
    task automatic io_read(input logic [9:0] port, input logic [7:0] exp, input string tag);
        address   = {10'h000, port};
        io_read_n = 1'b0;
        @(negedge clock);
        check(tag, data_bus_out, exp);
        io_read_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic set_addr(input logic [19:0] a);
        address = a;
        #1;
    endtask

    initial begin
        reset_n           = 1'b0;
        address           = 20'h00000;
        internal_data_bus = 8'h00;
        io_read_n         = 1'b1;
        io_write_n        = 1'b1;
        memory_read_n     = 1'b1;
        memory_write_n    = 1'b1;
        repeat (2) @(negedge clock);

        // Reset state
        check("rst_dbo", data_bus_out, 8'h00);
        check("rst_iosel", {7'd0, io_select_n}, 8'h01);
        check("rst_emsb", ems_vec(), 8'h00);
        check("rst_enable", {7'd0, ems_enable}, 8'h00);
        check("rst_map0", {1'b0, map_ems[0]}, 8'h00);
        reset_n = 1'b1;
        @(negedge clock);

        // T1: page0 valid page 5, enable with frame C0000h
        io_write(10'h260, 8'h85);
        io_write(10'h264, 8'h80);
        set_addr(20'hC0000);
        check("t1_emsb_c0000", ems_vec(), 8'h01);
        check("t1_map0", {1'b0, map_ems[0]}, 8'h05);
        check("t1_enable", {7'd0, ems_enable}, 8'h01);
        set_addr(20'hC4000);
        check("t1_emsb_c4000", ems_vec(), 8'h00);

        // T2: writes stall behind an active memory read, then drain in order
        memory_read_n = 1'b0;
        io_write(10'h261, 8'h83);
        io_write(10'h264, 8'h81);
        repeat (3) @(negedge clock);
        check("t2_map1_stalled", {1'b0, map_ems[1]}, 8'h00);
        io_read(10'h264, 8'h80, "t2_ctrl_stalled");
        set_addr(20'hC4000);
        check("t2_emsb_stalled", ems_vec(), 8'h00);
        memory_read_n = 1'b1;
        @(negedge clock);
        check("t2_map1_first", {1'b0, map_ems[1]}, 8'h03);
        check("t2_emsb_c_first", ems_vec(), 8'h02);
        @(negedge clock);
        check("t2_emsb_c_second", ems_vec(), 8'h00);
        set_addr(20'hD4000);
        check("t2_emsb_d_second", ems_vec(), 8'h02);

        // T3: overflow on third queued write, cleared by control read
        io_write(10'h264, 8'h00);
        check("t3_enable_off", {7'd0, ems_enable}, 8'h00);
        memory_write_n = 1'b0;
        io_write(10'h260, 8'h11);
        io_write(10'h261, 8'h22);
        io_write(10'h262, 8'h33);
        io_read(10'h260, 8'h85, "t3_pending_hidden");
        io_read(10'h264, 8'h40, "t3_ctrl_overflow");
        io_read(10'h264, 8'h00, "t3_ctrl_cleared");
        memory_write_n = 1'b1;
        repeat (2) @(negedge clock);
        io_read(10'h260, 8'h11, "t3_page0");
        io_read(10'h261, 8'h22, "t3_page1");
        io_read(10'h262, 8'h00, "t3_page2_dropped");

        // T4: frame E0000h, page3, then frame off
        io_write(10'h264, 8'h82);
        io_write(10'h263, 8'h9F);
        set_addr(20'hEC123);
        check("t4_emsb_ec123", ems_vec(), 8'h08);
        check("t4_map3", {1'b0, map_ems[3]}, 8'h1F);
        set_addr(20'hDC123);
        check("t4_emsb_dc123", ems_vec(), 8'h00);
        io_write(10'h264, 8'h83);
        set_addr(20'hEC123);
        check("t4_emsb_off_e", ems_vec(), 8'h00);
        set_addr(20'hFC123);
        check("t4_emsb_off_f", ems_vec(), 8'h00);

        // T5: long write pulse pushes once; window boundaries
        memory_read_n     = 1'b0;
        address           = 20'h00262;
        internal_data_bus = 8'h44;
        io_write_n        = 1'b0;
        repeat (10) @(negedge clock);
        io_write_n        = 1'b1;
        @(negedge clock);
        io_read(10'h264, 8'h83, "t5_no_overflow");
        check("t5_map2_stalled", {1'b0, map_ems[2]}, 8'h00);
        memory_read_n = 1'b1;
        @(negedge clock);
        io_read(10'h262, 8'h44, "t5_page2");
        io_read(10'h264, 8'h83, "t5_single_push");
        address   = 20'h002A0;
        io_read_n = 1'b0;
        #1;
        check("t5_iosel_outside", {7'd0, io_select_n}, 8'h01);
        @(negedge clock);
        check("t5_dbo_outside", data_bus_out, 8'h00);
        set_addr(20'h00264);
        check("t5_iosel_top", {7'd0, io_select_n}, 8'h00);
        set_addr(20'h00265);
        check("t5_iosel_past", {7'd0, io_select_n}, 8'h01);
        set_addr(20'h0025F);
        check("t5_iosel_below", {7'd0, io_select_n}, 8'h01);
        io_read_n = 1'b1;
        @(negedge clock);

        // T6: async reset with two writes queued
        memory_read_n = 1'b0;
        io_write(10'h260, 8'h55);
        io_write(10'h261, 8'h66);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_async_enable", {7'd0, ems_enable}, 8'h00);
        check("t6_async_map3", {1'b0, map_ems[3]}, 8'h00);
        @(negedge clock);
        reset_n       = 1'b1;
        memory_read_n = 1'b1;
        repeat (3) @(negedge clock);
        io_read(10'h260, 8'h00, "t6_page0");
        io_read(10'h261, 8'h00, "t6_page1");
        io_read(10'h264, 8'h00, "t6_ctrl");
        set_addr(20'hC0000);
        check("t6_emsb", ems_vec(), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
